// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);
  if (N % 2 != 0 || N < 4) begin : g_bad_n
    $error("booth_mul_seq: N must be even and >= 4");
  end
  localparam int W = 2*N+4;
  localparam int CW = $clog2(N/2+2);
  localparam logic [CW-1:0] LAST_S = CW'(N/2-1);
  localparam logic [CW-1:0] LAST_U = CW'(N/2);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [N+1:0] am;
  logic [N+2:0] bm, mag, ppv;
  logic [W-1:0] acc, acc_next, addend, cin;
  logic [CW-1:0] cnt;
  logic sgn, neg, last;
  logic [2:0] trip;
  assign trip = bm[2:0];
  assign last = cnt == (sgn ? LAST_S : LAST_U);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // negation folds into the add: inverted digit plus a carry-in at the digit's weight
  always_comb begin
    neg = trip[2] & ~(trip[1] & trip[0]);
    mag = (trip == 3'b011 || trip == 3'b100) ? {am, 1'b0} :
          (trip == 3'b000 || trip == 3'b111) ? '0 : {am[N+1], am};
    ppv = neg ? ~mag : mag;
    addend = {{(W-N-3){ppv[N+2]}}, ppv} << {cnt, 1'b0};
    cin = W'(neg) << {cnt, 1'b0};
    acc_next = acc + addend + cin;
  end
  always_comb begin
    next = state == IDLE ? (in_valid ? CALC : IDLE) :
           state == CALC ? (last ? DONE : CALC) :
           (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am <= '0;
      bm <= '0;
      acc <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      p <= '0;
    end else if (state == IDLE && in_valid) begin
      am <= {(is_signed ? {2{a[N-1]}} : 2'b00), a};
      bm <= {(is_signed ? {2{b[N-1]}} : 2'b00), b, 1'b0};
      acc <= '0;
      cnt <= '0;
      sgn <= is_signed;
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      bm <= bm >> 2;
      if (last) p <= acc_next[2*N-1:0];
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and randomised checks of booth_mul_seq at N=8, 16 and 6 against an arithmetic model.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] iv = '0, orr = '0, ir, ov, bz;
  logic [15:0] va = '0, vb = '0;
  logic sg = 1'b0;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [11:0] p6;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  booth_mul_seq #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(va[7:0]), .b(vb[7:0]), .is_signed(sg), .out_valid(ov[0]), .out_ready(orr[0]), .p(p8), .busy(bz[0]));
  booth_mul_seq #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(va), .b(vb), .is_signed(sg), .out_valid(ov[1]), .out_ready(orr[1]), .p(p16), .busy(bz[1]));
  booth_mul_seq #(.N(6)) u6 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(va[5:0]), .b(vb[5:0]), .is_signed(sg), .out_valid(ov[2]), .out_ready(orr[2]), .p(p6), .busy(bz[2]));
  function automatic int wid(int k);
    return k == 0 ? 8 : k == 1 ? 16 : 6;
  endfunction
  function automatic logic [31:0] gp(int k);
    return k == 0 ? {16'b0, p8} : k == 1 ? p16 : {20'b0, p6};
  endfunction
  // the product as the integers the operands denote, truncated to 2w bits
  function automatic logic [31:0] ref_mul(int w, logic [15:0] x, logic [15:0] y, bit s);
    longint ex, ey, pr;
    ex = longint'(x) & ((64'sd1 << w) - 1);
    ey = longint'(y) & ((64'sd1 << w) - 1);
    if (s && x[w-1]) ex -= (64'sd1 << w);
    if (s && y[w-1]) ey -= (64'sd1 << w);
    pr = ex * ey;
    return 32'(pr & ((64'sd1 << (2*w)) - 1));
  endfunction
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic op(int k, logic [15:0] x, logic [15:0] y, bit s, int hold, bit poke, string tag);
    int lat;
    logic [31:0] e;
    e = ref_mul(wid(k), x, y, s);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(ir[k]), 64'd1);
    va = x; vb = y; sg = s; iv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0; sg = ~s; va = 16'($urandom); vb = 16'($urandom);
    chk({tag, "_busy"}, 64'(bz[k]), 64'd1);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      if (poke) begin iv[k] = (lat == 0); va = 16'd9; end
      @(negedge clk);
      lat++;
    end
    iv[k] = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(s ? wid(k)/2 : wid(k)/2 + 1));
    chk({tag, "_p"}, 64'(gp(k)), 64'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_p"}, 64'(gp(k)), 64'(e));
      chk({tag, "_hold_ir_ov"}, {62'b0, ir[k], ov[k]}, 64'b01);
    end
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = 1'b0;
    chk({tag, "_post_ir_ov_bz"}, {61'b0, ir[k], ov[k], bz[k]}, 64'b100);
    chk({tag, "_post_p"}, 64'(gp(k)), 64'(e));
  endtask
  initial begin
    int k, h;
    bit s;
    repeat (2) @(negedge clk);
    chk("rst_ir", {61'b0, ir}, 64'b111);
    chk("rst_ov", {61'b0, ov}, 64'b000);
    chk("rst_bz", {61'b0, bz}, 64'b000);
    chk("rst_p", {p16, p8, 4'b0, p6}, 64'd0);
    rst_n = 1'b1;
    op(0, 16'd3, 16'd5, 1, 0, 0, "s3x5");
    op(0, 16'h80, 16'h80, 1, 1, 0, "s_m128sq");
    op(0, 16'h7f, 16'h80, 1, 0, 0, "s_127xm128");
    op(0, 16'hff, 16'hff, 1, 0, 0, "s_m1sq");
    op(0, 16'h00, 16'hb3, 1, 0, 0, "s_0xm77");
    op(0, 16'hff, 16'hff, 0, 0, 0, "u_255sq");
    op(0, 16'h80, 16'h02, 0, 0, 0, "u_128x2");
    op(0, 16'h80, 16'h02, 1, 0, 0, "s_m128x2");
    op(0, 16'h81, 16'h7f, 1, 10, 0, "backpressure");
    op(0, 16'h35, 16'hc6, 1, 2, 1, "poke_s");
    op(0, 16'he1, 16'h2b, 0, 0, 1, "poke_u");
    chk("no_second_accept", {61'b0, ir[0], ov[0], bz[0]}, 64'b100);
    @(negedge clk);
    va = 16'h55; vb = 16'h33; sg = 1'b1; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ir_ov_bz", {61'b0, ir[0], ov[0], bz[0]}, 64'b100);
    chk("abort_p", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 16'hfff9, 16'd6, 1, 0, 0, "m7x6");
    for (int i = 0; i < 2500; i++) begin
      k = $urandom_range(0, 2);
      s = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 2);
      op(k, 16'($urandom), 16'($urandom), s, h, 0, $sformatf("rnd%0d_n%0d_s%0d", i, wid(k), s));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
